pipe_stage_reg: RTL

//   Generic parametrised pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake, CTRL zeroed on flush/reset.
// Latency: 1 cycle from in_valid&in_ready to out_valid when the stage is empty or releasing.
// Backpressure: SKID=1 holds 2 entries, in_ready depends only on flops and stall; SKID=0 holds 1 entry, in_ready follows out_ready.
//
// Ports:
//   clk, reset (sync, active-low)     clock and reset; reset beats flush and stall
//   flush                             drops every held entry (and any beat fired that cycle) at the next edge
//   stall                             freezes the stage: no accept, no release, out_valid masked
//   in_valid/in_ready/in_ctrl/in_data upstream handshake and beat
//   out_valid/out_ready/out_ctrl/out_data downstream handshake and beat (out_ctrl is 0 while out_valid=0)
//   occupancy                         number of held entries (0..2)
module pipe_stage_reg #(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 8,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Main entry (drives outputs) and skid entry.
    logic              m_vld, s_vld;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic [1:0]        occ_q;

    logic              m_vld_n, s_vld_n;
    logic [CTRL_W-1:0] m_ctrl_n, s_ctrl_n;
    logic [DATA_W-1:0] m_data_n, s_data_n;

    logic in_fire;
    logic out_fire;

    assign out_valid = m_vld & ~stall;
    assign out_ctrl  = out_valid ? m_ctrl : '0;
    assign out_data  = m_data;
    assign occupancy = occ_q;

    // With the skid entry, in_ready only looks at the S flop, so there is no
    // combinational path from out_ready back upstream.
    assign in_ready = (SKID != 0) ? (~stall & ~s_vld)
                                  : (~stall & (~m_vld | out_ready));

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        m_vld_n  = m_vld;
        m_ctrl_n = m_ctrl;
        m_data_n = m_data;
        s_vld_n  = s_vld;
        s_ctrl_n = s_ctrl;
        s_data_n = s_data;

        if (flush) begin
            // Anything fired this cycle is dropped along with the held entries.
            m_vld_n  = 1'b0;
            s_vld_n  = 1'b0;
            m_ctrl_n = '0;
            s_ctrl_n = '0;
            if (CLEAR_DATA != 0) begin
                m_data_n = '0;
                s_data_n = '0;
            end
        end else if (SKID != 0) begin
            if (!m_vld || out_fire) begin
                // M is free (or being released) this cycle.
                if (s_vld) begin
                    // Oldest beat sits in S: promote it to keep FIFO order.
                    m_vld_n  = 1'b1;
                    m_ctrl_n = s_ctrl;
                    m_data_n = s_data;
                    s_vld_n  = in_fire;
                    if (in_fire) begin
                        s_ctrl_n = in_ctrl;
                        s_data_n = in_data;
                    end
                end else if (in_fire) begin
                    m_vld_n  = 1'b1;
                    m_ctrl_n = in_ctrl;
                    m_data_n = in_data;
                end else begin
                    m_vld_n = 1'b0;
                end
            end else if (in_fire) begin
                // M held downstream: park the new beat in S.
                s_vld_n  = 1'b1;
                s_ctrl_n = in_ctrl;
                s_data_n = in_data;
            end
        end else begin
            if (in_fire) begin
                m_vld_n  = 1'b1;
                m_ctrl_n = in_ctrl;
                m_data_n = in_data;
            end else if (out_fire) begin
                m_vld_n = 1'b0;
            end
            s_vld_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_vld  <= 1'b0;
            s_vld  <= 1'b0;
            m_ctrl <= '0;
            s_ctrl <= '0;
            // Data is cleared on reset regardless of CLEAR_DATA so it is never X.
            m_data <= '0;
            s_data <= '0;
            occ_q  <= 2'd0;
        end else begin
            m_vld  <= m_vld_n;
            s_vld  <= s_vld_n;
            m_ctrl <= m_ctrl_n;
            s_ctrl <= s_ctrl_n;
            m_data <= m_data_n;
            s_data <= s_data_n;
            occ_q  <= {1'b0, m_vld_n} + {1'b0, s_vld_n};
        end
    end

endmodule
